// File: rtl/ss_sign_mag_decoder.sv
// Signed stochastic bitstream to two's-complement decoder, counting over 2^WINDOW_BITS samples.
// Define SS_DEC_CONTINUOUS_EN to make the block free-run after the first START.
module ss_sign_mag_decoder #(
    parameter int WINDOW_BITS = 8
) (
    input  logic                   CLK,
    input  logic                   INIT_N,
    input  logic                   START,
    input  logic                   IN,
    input  logic                   SIGN,
    input  logic                   ACK,
    output logic                   BUSY,
    output logic                   VALID,
    output logic [WINDOW_BITS:0]   VALUE,
    output logic                   SAT,
    output logic                   OVERRUN
);
    // state | meaning
    // IDLE  | waiting for START, result registers hold
    // ACCUM | counting samples of the current window

    localparam int ACC_W = WINDOW_BITS + 2;
    localparam logic [ACC_W-1:0]     ACC_POS_FULL  = ACC_W'(1) << WINDOW_BITS;
    localparam logic [WINDOW_BITS:0] VALUE_POS_MAX = {1'b0, {WINDOW_BITS{1'b1}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state, state_nxt;
    logic [WINDOW_BITS-1:0] cnt;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       step;
    logic [ACC_W-1:0]       acc_sum;
    logic                   win_start;
    logic                   win_last;

    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        win_start = 1'b0;
        win_last  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = ACCUM;
                    win_start = 1'b1;
                end
            end
            ACCUM: begin
                if (cnt == '0) begin
                    win_last = 1'b1;
`ifdef SS_DEC_CONTINUOUS_EN
                    state_nxt = ACCUM;
`else
                    state_nxt = IDLE;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        step = '0;
        if (IN) step = SIGN ? '1 : ACC_W'(1);
    end

    assign acc_sum = acc + step;
    assign BUSY    = (state == ACCUM);

    // cnt is a down-counter of remaining samples; zero marks the final sample
    always_ff @(posedge CLK or negedge INIT_N) begin
        if (!INIT_N) begin
            cnt     <= '0;
            acc     <= '0;
            VALID   <= 1'b0;
            VALUE   <= '0;
            SAT     <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            if (win_start || win_last) begin
                cnt <= '1;
                acc <= '0;
            end else if (state == ACCUM) begin
                cnt <= cnt - WINDOW_BITS'(1);
                acc <= acc_sum;
            end

            if (win_last) begin
                VALUE <= (acc_sum == ACC_POS_FULL) ? VALUE_POS_MAX : acc_sum[WINDOW_BITS:0];
                SAT   <= (acc_sum == ACC_POS_FULL);
                VALID <= 1'b1;
                if (VALID && !ACK) OVERRUN <= 1'b1;
            end else if (ACK) begin
                VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ss_sign_mag_decoder.sv
// Bench for ss_sign_mag_decoder (WINDOW_BITS=3): directed windows with literal results,
// then random traffic checked every cycle against an integer window model.
module tb_ss_sign_mag_decoder;
    localparam int WB = 3;
    localparam int N  = 1 << WB;

    logic          CLK = 1'b0;
    logic          INIT_N = 1'b0;
    logic          START = 1'b0;
    logic          IN = 1'b0;
    logic          SIGN = 1'b0;
    logic          ACK = 1'b0;
    logic          BUSY, VALID, SAT, OVERRUN;
    logic [WB:0]   VALUE;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    ss_sign_mag_decoder #(.WINDOW_BITS(WB)) dut (
        .CLK(CLK), .INIT_N(INIT_N), .START(START), .IN(IN), .SIGN(SIGN), .ACK(ACK),
        .BUSY(BUSY), .VALID(VALID), .VALUE(VALUE), .SAT(SAT), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Window model: sample index and running signed sum as plain integers
    int m_k = 0, m_sum = 0, m_value = 0;
    bit m_busy = 0, m_valid = 0, m_sat = 0, m_ovr = 0;

    always @(posedge CLK or negedge INIT_N) begin
        int s;
        bit done;
        if (!INIT_N) begin
            m_busy <= 0; m_k <= 0; m_sum <= 0; m_valid <= 0;
            m_value <= 0; m_sat <= 0; m_ovr <= 0;
        end else begin
            done = 0;
            s = m_sum + (IN ? (SIGN ? -1 : 1) : 0);
            if (!m_busy) begin
                if (START) begin
                    m_busy <= 1; m_k <= 0; m_sum <= 0;
                end
            end else if (m_k == N - 1) begin
                done = 1;
                m_value <= (s > N - 1) ? N - 1 : s;
                m_sat   <= (s == N);
                m_k <= 0; m_sum <= 0;
`ifndef SS_DEC_CONTINUOUS_EN
                m_busy <= 0;
`endif
            end else begin
                m_k <= m_k + 1; m_sum <= s;
            end
            if (done) begin
                m_valid <= 1;
                if (m_valid && !ACK) m_ovr <= 1;
            end else if (ACK) begin
                m_valid <= 0;
            end
        end
    end

    always @(negedge CLK) begin
        logic [WB:0] ev;
        if (chk_en) begin
            ev = (WB+1)'(m_value);
            cmp("model_busy",    32'(BUSY),    32'(m_busy));
            cmp("model_valid",   32'(VALID),   32'(m_valid));
            cmp("model_value",   32'(VALUE),   32'(ev));
            cmp("model_sat",     32'(SAT),     32'(m_sat));
            cmp("model_overrun", 32'(OVERRUN), 32'(m_ovr));
        end
    end

    task automatic step(input bit st, input bit i, input bit s, input bit a);
        @(negedge CLK);
        START = st; IN = i; SIGN = s; ACK = a;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        cmp("reset_busy",  32'(BUSY),  0);
        cmp("reset_valid", 32'(VALID), 0);
        cmp("reset_value", 32'(VALUE), 0);
        INIT_N = 1'b1;
        chk_en = 1'b1;

`ifndef SS_DEC_CONTINUOUS_EN
        // 5 up, 2 down, 1 idle -> +3
        step(1, 0, 0, 0);
        repeat (5) step(0, 1, 0, 0);
        repeat (2) step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        cmp("a_value", 32'(VALUE), 32'h3);
        cmp("a_sat",   32'(SAT),   0);
        cmp("a_valid", 32'(VALID), 1);
        cmp("a_busy",  32'(BUSY),  0);
        step(0, 0, 0, 1);

        // all up saturates at +7
        step(1, 0, 0, 0);
        repeat (N) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        cmp("b_value", 32'(VALUE), 32'h7);
        cmp("b_sat",   32'(SAT),   1);
        // ACK and START together, all down -> -8 exact
        step(1, 0, 0, 1);
        repeat (N) step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        cmp("b_neg_value", 32'(VALUE), 32'h8);
        cmp("b_neg_sat",   32'(SAT),   0);
        cmp("b_neg_valid", 32'(VALID), 1);

        // unacknowledged result overwritten -> OVERRUN
        step(1, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        cmp("c_overrun", 32'(OVERRUN), 1);
        cmp("c_value",   32'(VALUE),   32'h3);

        // async reset after sample 4
        step(1, 0, 0, 0);
        repeat (4) step(0, 1, 0, 0);
        @(negedge CLK);
        INIT_N = 1'b0;
        START = 0; IN = 0; SIGN = 0; ACK = 0;
        #1;
        cmp("d_busy",    32'(BUSY),    0);
        cmp("d_valid",   32'(VALID),   0);
        cmp("d_value",   32'(VALUE),   0);
        cmp("d_overrun", 32'(OVERRUN), 0);
        repeat (2) @(negedge CLK);
        INIT_N = 1'b1;
        step(1, 0, 0, 0);
        repeat (N) step(0, 0, $urandom_range(0, 1), 0);
        step(0, 0, 0, 0);
        cmp("d_zero_value", 32'(VALUE), 0);
        cmp("d_zero_valid", 32'(VALID), 1);

        // completion coincides with ACK: no OVERRUN, VALID stays; +7 is exact, not saturated
        step(1, 0, 0, 0);
        repeat (N - 1) step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        cmp("c2_overrun", 32'(OVERRUN), 0);
        cmp("c2_valid",   32'(VALID),   1);
        cmp("c2_value",   32'(VALUE),   32'h7);
        cmp("c2_sat",     32'(SAT),     0);
        step(0, 0, 0, 1);

        // START mid-window is ignored; completion still at edge 8
        step(1, 0, 0, 0);
        for (int k = 1; k <= N; k++) begin
            step((k == 2) || (k == 5), (k <= 6), 1, 0);
            if (k == N) begin
                cmp("e_busy_pre",  32'(BUSY),  1);
                cmp("e_valid_pre", 32'(VALID), 0);
            end
        end
        step(0, 0, 0, 0);
        cmp("e_busy",  32'(BUSY),  0);
        cmp("e_valid", 32'(VALID), 1);
        cmp("e_value", 32'(VALUE), 32'hA);
`else
        // free-running: single START, constant +1, ACK each result
        step(1, 1, 0, 0);
        for (int e = 1; e <= 3 * N; e++) begin
            @(posedge CLK);
            #1;
            cmp("cont_busy", 32'(BUSY), 1);
            if (e % N == 0) begin
                cmp("cont_valid", 32'(VALID), 1);
                cmp("cont_value", 32'(VALUE), 32'h7);
                cmp("cont_sat",   32'(SAT),   1);
            end
            ACK = VALID;
        end
        ACK = 0;
        @(negedge CLK);
        cmp("cont_overrun", 32'(OVERRUN), 0);
`endif

        // random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0);
            if (c == 1000) begin
                @(negedge CLK);
                INIT_N = 1'b0;
                @(negedge CLK);
                INIT_N = 1'b1;
            end
        end
        step(0, 0, 0, 0);
        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ss_sign_mag_decoder.md
# ss_sign_mag_decoder

Converts a signed stochastic bitstream (magnitude bit plus sign bit, as produced by the stochastic add/sub stages) back into a two's-complement binary value by counting over a fixed window of 2^WINDOW_BITS cycles. It sits at the output boundary of the stochastic datapath and feeds binary consumers such as readout, loss computation and weight-update logic. It returns results through a VALID/ACK handshake.

## Interface
- WINDOW_BITS, 8, log2 of window length; N = 2^WINDOW_BITS samples per conversion
- CLK  in  1  clock, all state updates on rising edge
- INIT_N  in  1  asynchronous active-low reset
- START  in  1  begin a conversion; sampled only in IDLE
- IN  in  1  stochastic magnitude bit
- SIGN  in  1  sign of IN (0 = +, 1 = −)
- ACK  in  1  consumer accepts current VALUE
- BUSY  out  1  conversion window in progress
- VALID  out  1  VALUE holds an unconsumed result
- VALUE  out  WINDOW_BITS+1  signed result, two's complement
- SAT  out  1  VALUE was clipped at positive full scale; latched with VALUE
- OVERRUN  out  1  sticky; a result was overwritten while unacknowledged

## Operation
- States: IDLE, ACCUM.
- IDLE: START=1 → ACCUM. Sample counter and accumulator are cleared to 0.
- ACCUM, per cycle: if IN&~SIGN, acc += 1. If IN&SIGN, acc −= 1. Otherwise acc is held.
- Accumulator is WINDOW_BITS+2 bits signed. Its range is [−N, +N].
- The counter counts samples 1..N. On sample N, the final sample is folded in and the result is latched:
  - VALUE = acc_final clipped to [−N, N−1].
  - SAT = 1 only if acc_final = +N, where VALUE = N−1. The negative extreme −N is exact, so SAT = 0.
  - VALID ← 1.
  - If VALID was 1 and ACK was 0 on that same edge, OVERRUN ← 1.
  - Next state: IDLE.
- ACK=1 while VALID=1 clears VALID next edge. ACK while VALID=0 has no effect.
- Completion and ACK on the same edge: the new result is latched, VALID stays 1, and OVERRUN is not set.
- START during ACCUM is ignored. START in IDLE while VALID=1 is accepted, and the old result remains until overwritten.
- VALUE and SAT hold between results and are unaffected by ACK.
- OVERRUN is cleared only by INIT_N.

## Timing
- Reset (INIT_N=0, asynchronous): state IDLE; counter, accumulator, BUSY, VALID, VALUE, SAT and OVERRUN are all 0.
- START seen at edge 0 → BUSY=1 after edge 0. Samples are taken at edges 1..N.
- VALUE, SAT and VALID update at edge N. Latency from START edge to VALID visible is N edges. BUSY=0 after edge N.
- Back-to-back: START at edge N+1 is the earliest next start. This gives one dead cycle per conversion.
- Reset asserted mid-window discards the partial accumulation immediately. No VALID is produced.

## Configuration
- SS_DEC_CONTINUOUS_EN defined:
  - After the first START, the block free-runs.
  - At edge N the result is latched as usual. The counter wraps and the accumulator clears, and sample 1 of the next window is taken at edge N+1.
  - BUSY stays 1 with no dead cycle. START is ignored until reset.
  - Results arrive every N cycles, and OVERRUN rules apply unchanged.
- Not defined: single-shot behaviour as above, returning to IDLE after each window.

## Test plan
- WINDOW_BITS=3, START, then samples (IN,SIGN) = 5×(1,0), 2×(1,1), 1×(0,x) → at edge 8: VALUE=+3 (0011), SAT=0, VALID=1, BUSY=0.
- 8×(1,0) → VALUE=+7 (0111), SAT=1. Then ACK, START and 8×(1,1) → VALUE=−8 (1000), SAT=0.
- Complete one conversion without ACK, START again, and finish → OVERRUN=1 and VALUE replaced. Repeat with ACK on the completion edge → OVERRUN unchanged, VALID=1.
- INIT_N pulsed low after sample 4 → BUSY, VALID, VALUE and OVERRUN are 0 asynchronously. A following START with 8×(0,x) gives VALUE=0.
- START pulsed at samples 2 and 5 of an active window → ignored. Completion still occurs exactly at edge 8 after the original START.
- SS_DEC_CONTINUOUS_EN, single START, IN=1 SIGN=0 constant, ACK every result → VALID at edges 8, 16, 24, each VALUE=+7 with SAT=1, BUSY never drops, OVERRUN=0.
